// File: rtl/strobed_memory_responder.sv
// Responder for a level-held strobe memory protocol: detects the strobe rising
// edge, performs one read or write on an internal array and pulses ack.
module strobed_memory_responder #(
  parameter int MEM_SIZE      = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     strobe,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  output logic [DATA_WIDTH-1:0]    out,
  output logic                     ready,
  output logic                     ack,
  output logic                     error,
  output logic [COUNT_WIDTH-1:0]   writes,
  output logic [COUNT_WIDTH-1:0]   reads
);

  localparam int PW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t                   state_q;
  logic [PW-1:0]            clear_ptr_q;
  logic                     strobe_q;
  logic [DATA_WIDTH-1:0]    out_q;
  logic                     ready_q;
  logic                     ack_q;
  logic                     error_q;
  logic [COUNT_WIDTH-1:0]   writes_q;
  logic [COUNT_WIDTH-1:0]   reads_q;
  logic [DATA_WIDTH-1:0]    mem_q [MEM_SIZE];

  logic                     edge_s;
  logic                     in_range_s;
  logic [PW-1:0]            mem_idx_s;
  logic [COUNT_WIDTH-1:0]   writes_d;
  logic [COUNT_WIDTH-1:0]   reads_d;

  // Request decode: strobe rising edge, address range check, counter increments
  always_comb begin
    edge_s     = strobe & ~strobe_q;
    in_range_s = (32'(address) < 32'(MEM_SIZE));
    mem_idx_s  = PW'(address);
    writes_d   = writes_q + COUNT_WIDTH'(1);
    reads_d    = reads_q + COUNT_WIDTH'(1);
  end

  // Control FSM, array access and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= {PW{1'b0}};
      strobe_q    <= 1'b0;
      out_q       <= {DATA_WIDTH{1'b0}};
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      writes_q    <= {COUNT_WIDTH{1'b0}};
      reads_q     <= {COUNT_WIDTH{1'b0}};
    end else begin
      strobe_q <= strobe;
      ack_q    <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          mem_q[clear_ptr_q] <= {DATA_WIDTH{1'b0}};
          clear_ptr_q        <= clear_ptr_q + PW'(1);
          ready_q            <= 1'b0;
          if (clear_ptr_q == PW'(MEM_SIZE - 1)) begin
            state_q <= ST_WAIT_LOW;
          end
        end
        ST_IDLE: begin
          if (edge_s) begin
            ack_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_WAIT_LOW;
            if (!in_range_s) begin
              error_q <= 1'b1;
            end else if (write) begin
              mem_q[mem_idx_s] <= in;
              writes_q         <= writes_d;
            end else begin
              out_q   <= mem_q[mem_idx_s];
              reads_q <= reads_d;
            end
          end
        end
        // A strobe still high here (including one left over from CLEAR) must drop first
        ST_WAIT_LOW: begin
          if (!strobe) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_CLEAR;
          clear_ptr_q <= {PW{1'b0}};
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out    = out_q;
    ready  = ready_q;
    ack    = ack_q;
    error  = error_q;
    writes = writes_q;
    reads  = reads_q;
  end

endmodule

// File: tb/tb_strobed_memory_responder.sv
// Directed bench for strobed_memory_responder; stimulus pushes hand-computed
// expectations, an ack-driven monitor pops and compares them.
module tb_strobed_memory_responder;

  localparam int MEM_SIZE = 8;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          strobe;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] in_d;
  logic [DW-1:0] out;
  logic          ready;
  logic          ack;
  logic          error;
  logic [CW-1:0] writes;
  logic [CW-1:0] reads;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          err;
    logic [CW-1:0] wr;
    logic [CW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  strobed_memory_responder #(
    .MEM_SIZE(MEM_SIZE), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .write(write),
    .address(address), .in(in_d), .out(out), .ready(ready), .ack(ack),
    .error(error), .writes(writes), .reads(reads)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: ack=1 with no request outstanding at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_out", 32'(out), 32'(mon_e.out));
        check("ack_error", 32'(error), 32'(mon_e.err));
        check("ack_writes", 32'(writes), 32'(mon_e.wr));
        check("ack_reads", 32'(reads), 32'(mon_e.rd));
      end
    end
  end

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hi, input logic [DW-1:0] eo, input logic ee,
                        input logic [CW-1:0] ew, input logic [CW-1:0] er);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    check("ready_before_req", 32'(ready), 32'd1);
    exp_q.push_back(exp_t'{eo, ee, ew, er});
    write   = w;
    address = a;
    in_d    = d;
    strobe  = 1'b1;
    cyc(hi);
    check("ready_low_while_held", 32'(ready), 32'd0);
    strobe  = 1'b0;
    write   = ~w;
    address = AW'($urandom);
    in_d    = DW'($urandom);
    cyc(1);
    check("ready_after_drop", 32'(ready), 32'd1);
    check("ack_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; strobe = 1'b0; write = 1'b0; address = 8'd0; in_d = 8'd0;
    cyc(2);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_writes", 32'(writes), 32'd0);
    check("rst_reads", 32'(reads), 32'd0);
    reset = 1'b0;
    cyc(MEM_SIZE);
    check("ready_during_clear", 32'(ready), 32'd0);
    cyc(1);
    check("ready_after_clear", 32'(ready), 32'd1);

    // write 2@1, 3@2, 5@3 then read them back
    do_req(1'b1, 8'd1, 8'h02, 1, 8'h00, 1'b0, 16'd1, 16'd0);
    do_req(1'b1, 8'd2, 8'h03, 1, 8'h00, 1'b0, 16'd2, 16'd0);
    do_req(1'b1, 8'd3, 8'h05, 1, 8'h00, 1'b0, 16'd3, 16'd0);
    do_req(1'b0, 8'd2, 8'hFF, 1, 8'h03, 1'b0, 16'd3, 16'd1);
    do_req(1'b0, 8'd0, 8'hFF, 1, 8'h00, 1'b0, 16'd3, 16'd2);
    do_req(1'b0, 8'd1, 8'hFF, 1, 8'h02, 1'b0, 16'd3, 16'd3);
    do_req(1'b0, 8'd3, 8'hFF, 1, 8'h05, 1'b0, 16'd3, 16'd4);

    // strobe held high for 5 cycles: one request only
    do_req(1'b1, 8'd4, 8'h7E, 5, 8'h05, 1'b0, 16'd4, 16'd4);
    do_req(1'b0, 8'd4, 8'h00, 1, 8'h7E, 1'b0, 16'd4, 16'd5);

    // out-of-range accesses: sticky error, counters and out unchanged
    do_req(1'b0, 8'd8,   8'h00, 1, 8'h7E, 1'b1, 16'd4, 16'd5);
    do_req(1'b1, 8'd255, 8'h99, 1, 8'h7E, 1'b1, 16'd4, 16'd5);
    do_req(1'b0, 8'd5,   8'h00, 1, 8'h00, 1'b1, 16'd4, 16'd6);
    do_req(1'b1, 8'd0,   8'hAA, 1, 8'h00, 1'b1, 16'd5, 16'd6);
    do_req(1'b0, 8'd0,   8'h00, 1, 8'hAA, 1'b1, 16'd5, 16'd7);

    // reset, then reset again mid-sweep: array and status cleared
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    check("rst2_out", 32'(out), 32'd0);
    check("rst2_error", 32'(error), 32'd0);
    reset = 1'b0;
    do_req(1'b0, 8'd0, 8'h00, 1, 8'h00, 1'b0, 16'd0, 16'd1);

    // strobe held high across the end of the sweep is not a request
    strobe = 1'b1; write = 1'b1; address = 8'd6; in_d = 8'h66;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(MEM_SIZE + 4);
    check("stuck_ready", 32'(ready), 32'd0);
    check("stuck_writes", 32'(writes), 32'd0);
    check("stuck_reads", 32'(reads), 32'd0);
    strobe = 1'b0;
    cyc(1);
    check("stuck_ready_after_drop", 32'(ready), 32'd1);
    do_req(1'b1, 8'd7, 8'h11, 1, 8'h00, 1'b0, 16'd1, 16'd0);
    do_req(1'b0, 8'd7, 8'h00, 1, 8'h11, 1'b0, 16'd1, 16'd1);
    do_req(1'b0, 8'd6, 8'h00, 1, 8'h00, 1'b0, 16'd1, 16'd2);

    cyc(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
